// File: rtl/unidad_busqueda.sv
`timescale 1ns/1ps
// Instruction fetch sequencer: streams a loadable program memory into the chocorrol
// datapath one word per clock, inserting all-zero no-ops whenever nothing new is issued.
module unidad_busqueda #(
    parameter int                     ANCHO_INSTR = 20,
    parameter int                     PROF        = 32,
    parameter logic [ANCHO_INSTR-1:0] PARO        = 20'hFFFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inicio,
    input  logic                     pausa,
    input  logic                     carga_we,
    input  logic [$clog2(PROF)-1:0]  carga_dir,
    input  logic [ANCHO_INSTR-1:0]   carga_dato,
    output logic [ANCHO_INSTR-1:0]   instr,
    output logic                     instr_valida,
    output logic [$clog2(PROF)-1:0]  pc,
    output logic [$clog2(PROF):0]    num_instr,
    output logic                     ocupado,
    output logic                     fin
);
    localparam int AW = $clog2(PROF);
    localparam logic [AW-1:0] PC_MAX  = AW'(PROF - 1);
    localparam logic [AW-1:0] PC_UNO  = AW'(1);
    localparam logic [AW:0]   NUM_UNO = (AW + 1)'(1);

    typedef enum logic [1:0] {REPOSO, EJECUTA, FIN} estado_t;

    estado_t                estado_q;
    logic [AW-1:0]          pc_q;
    logic [AW:0]            num_q;
    logic [ANCHO_INSTR-1:0] instr_q;
    logic                   valida_q;
    logic [ANCHO_INSTR-1:0] mem_q [PROF];
    logic [ANCHO_INSTR-1:0] palabra;

    assign palabra = mem_q[pc_q];

    // Program memory has no reset so a program survives rst_n; loads are locked out while running.
    always_ff @(posedge clk) begin
        if (carga_we && (estado_q != EJECUTA)) begin
            mem_q[carga_dir] <= carga_dato;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            pc_q     <= '0;
            num_q    <= '0;
            instr_q  <= '0;
            valida_q <= 1'b0;
        end else begin
            valida_q <= 1'b0;
            case (estado_q)
                REPOSO, FIN: begin
                    if (inicio) begin
                        estado_q <= EJECUTA;
                        pc_q     <= '0;
                        num_q    <= '0;
                    end
                end
                EJECUTA: begin
                    if (!pausa) begin
                        if (palabra == PARO) begin
                            estado_q <= FIN;
                        end else begin
                            instr_q  <= palabra;
                            valida_q <= 1'b1;
                            num_q    <= num_q + NUM_UNO;
                            // The last word stops the run instead of wrapping back to 0.
                            if (pc_q == PC_MAX) begin
                                estado_q <= FIN;
                            end else begin
                                pc_q <= pc_q + PC_UNO;
                            end
                        end
                    end
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign instr        = valida_q ? instr_q : '0;
    assign instr_valida = valida_q;
    assign pc           = pc_q;
    assign num_instr    = num_q;
    assign ocupado      = (estado_q == EJECUTA);
    assign fin          = (estado_q == FIN);

endmodule

// File: tb/tb_unidad_busqueda.sv
`timescale 1ns/1ps
// Bench for unidad_busqueda: a queue-based program model predicts every cycle's outputs,
// with literal checks from the directed scenarios pinning the model.
module tb_unidad_busqueda;
    localparam int W    = 20;
    localparam int PROF = 32;
    localparam int AW   = 5;
    localparam logic [W-1:0] PARO = 20'hFFFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          inicio = 1'b0;
    logic          pausa = 1'b0;
    logic          carga_we = 1'b0;
    logic [AW-1:0] carga_dir = '0;
    logic [W-1:0]  carga_dato = '0;
    logic [W-1:0]  instr;
    logic          instr_valida;
    logic [AW-1:0] pc;
    logic [AW:0]   num_instr;
    logic          ocupado;
    logic          fin;

    always #5 clk = ~clk;

    unidad_busqueda #(.ANCHO_INSTR(W), .PROF(PROF), .PARO(PARO)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .pausa(pausa),
        .carga_we(carga_we), .carga_dir(carga_dir), .carga_dato(carga_dato),
        .instr(instr), .instr_valida(instr_valida), .pc(pc),
        .num_instr(num_instr), .ocupado(ocupado), .fin(fin)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: program captured as a queue of words to issue when the run starts.
    logic [W-1:0] m_mem [PROF];
    logic [W-1:0] m_cola [$];
    bit           m_por_paro;
    int           m_est;     // 0 idle, 1 running, 2 finished
    int           m_num;
    logic         m_valid;
    logic [W-1:0] m_instr;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nombre, $time, act, exp);
        end
    endtask

    task automatic modelo_reset;
        m_est   = 0;
        m_num   = 0;
        m_valid = 1'b0;
        m_instr = '0;
    endtask

    task automatic modelo(input logic st, input logic pa, input logic we,
                          input logic [AW-1:0] dir, input logic [W-1:0] dato);
        if (m_est != 1) begin
            m_valid = 1'b0;
            if (we) m_mem[dir] = dato;
            if (st) begin
                m_cola.delete();
                m_por_paro = 1'b0;
                for (int i = 0; i < PROF; i++) begin
                    if (m_mem[i] == PARO) begin
                        m_por_paro = 1'b1;
                        break;
                    end
                    m_cola.push_back(m_mem[i]);
                end
                m_est = 1;
                m_num = 0;
            end
        end else if (pa) begin
            m_valid = 1'b0;
        end else if (m_cola.size() == 0) begin
            m_valid = 1'b0;
            m_est   = 2;
        end else begin
            m_instr = m_cola.pop_front();
            m_valid = 1'b1;
            m_num++;
            if (m_cola.size() == 0 && !m_por_paro) m_est = 2;
        end
    endtask

    task automatic compara;
        int m_pc;
        m_pc = (m_num >= PROF) ? PROF - 1 : m_num;
        chk("instr",        32'(instr),        m_valid ? 32'(m_instr) : 32'd0);
        chk("instr_valida", 32'(instr_valida), 32'(m_valid));
        chk("pc",           32'(pc),           32'(m_pc));
        chk("num_instr",    32'(num_instr),    32'(m_num));
        chk("ocupado",      32'(ocupado),      32'(m_est == 1));
        chk("fin",          32'(fin),          32'(m_est == 2));
    endtask

    task automatic tick(input logic st, input logic pa, input logic we,
                        input logic [AW-1:0] dir, input logic [W-1:0] dato);
        @(negedge clk);
        inicio = st; pausa = pa; carga_we = we; carga_dir = dir; carga_dato = dato;
        @(posedge clk);
        modelo(st, pa, we, dir, dato);
        #1;
        compara();
    endtask

    task automatic idle;
        tick(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic carga(input logic [AW-1:0] dir, input logic [W-1:0] dato);
        tick(1'b0, 1'b0, 1'b1, dir, dato);
    endtask

    task automatic arranca;
        tick(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic hasta_fin(input string nombre);
        for (int c = 0; c < 100 && fin !== 1'b1; c++) idle();
        chk(nombre, 32'(fin), 32'd1);
    endtask

    task automatic pulso_reset;
        @(negedge clk);
        inicio = 1'b0; pausa = 1'b0; carga_we = 1'b0;
        #2 rst_n = 1'b0;
        #0.5;
        modelo_reset();
        compara();
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        #0.5 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < PROF; i++) m_mem[i] = '0;
        modelo_reset();
        m_por_paro = 1'b0;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        compara();
        chk("por_fin", 32'(fin), 32'd0);
        chk("por_pc", 32'(pc), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Basic program ending in halt
        carga(5'd0, 20'h4A3E2);
        carga(5'd1, 20'h8C461);
        carga(5'd2, PARO);
        arranca();
        chk("t1_ocupado", 32'(ocupado), 32'd1);
        idle();
        chk("t1_w0", 32'(instr), 32'h4A3E2);
        chk("t1_v0", 32'(instr_valida), 32'd1);
        idle();
        chk("t1_w1", 32'(instr), 32'h8C461);
        idle();
        chk("t1_halt_instr", 32'(instr), 32'd0);
        chk("t1_fin", 32'(fin), 32'd1);
        chk("t1_num", 32'(num_instr), 32'd2);
        chk("t1_pc", 32'(pc), 32'd2);

        // Two pause cycles after the first word
        arranca();
        idle();
        chk("t2_w0", 32'(instr), 32'h4A3E2);
        tick(1'b0, 1'b1, 1'b0, '0, '0);
        chk("t2_nop0", 32'(instr), 32'd0);
        chk("t2_pc_hold", 32'(pc), 32'd1);
        tick(1'b0, 1'b1, 1'b0, '0, '0);
        chk("t2_nop1", 32'(instr), 32'd0);
        idle();
        chk("t2_w1", 32'(instr), 32'h8C461);
        idle();
        chk("t2_fin", 32'(fin), 32'd1);
        chk("t2_num", 32'(num_instr), 32'd2);

        // Full memory, no halt: run stops at the last word
        for (int i = 0; i < PROF; i++) carga(AW'(i), W'(i + 1));
        arranca();
        for (int i = 0; i < PROF; i++) begin
            idle();
            chk("t3_word", 32'(instr), 32'(i + 1));
        end
        chk("t3_fin_last", 32'(fin), 32'd1);
        chk("t3_pc", 32'(pc), 32'd31);
        chk("t3_num", 32'(num_instr), 32'd32);
        idle();
        chk("t3_nowrap", 32'(instr_valida), 32'd0);
        chk("t3_pc_hold", 32'(pc), 32'd31);

        // Load during run is dropped; load with start in FIN is seen
        arranca();
        tick(1'b0, 1'b0, 1'b1, 5'd0, 20'h12345);
        hasta_fin("t4_fin_a");
        arranca();
        idle();
        chk("t4_orig_w0", 32'(instr), 32'd1);
        hasta_fin("t4_fin_b");
        tick(1'b1, 1'b0, 1'b1, 5'd0, 20'hABCDE);
        idle();
        chk("t4_new_w0", 32'(instr), 32'hABCDE);
        hasta_fin("t4_fin_c");

        // Reset mid-run after 3 words, then replay
        arranca();
        idle(); idle(); idle();
        pulso_reset();
        arranca();
        idle();
        chk("t5_replay_w0", 32'(instr), 32'hABCDE);
        chk("t5_replay_pc", 32'(pc), 32'd1);
        hasta_fin("t5_fin");

        // Halt at address 0
        carga(5'd0, PARO);
        arranca();
        idle();
        chk("t6_fin", 32'(fin), 32'd1);
        chk("t6_num", 32'(num_instr), 32'd0);
        chk("t6_valid", 32'(instr_valida), 32'd0);
        idle();

        // Randomized programs, pauses, ignored loads and starts
        for (int it = 0; it < 15; it++) begin
            int nl;
            nl = $urandom_range(0, 8);
            for (int k = 0; k < nl; k++) begin
                carga(AW'($urandom), ($urandom_range(0, 9) == 0) ? PARO : W'($urandom));
            end
            tick(1'b1, 1'b0, ($urandom_range(0, 1) == 0), AW'($urandom), W'($urandom));
            for (int c = 0; c < 150 && fin !== 1'b1; c++) begin
                tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0), AW'($urandom), W'($urandom));
            end
            chk("rand_fin", 32'(fin), 32'd1);
            if ($urandom_range(0, 3) == 0) pulso_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
